// File: rtl/ps2_key_decoder_pkg.sv
// Shared game-key definitions: PS/2 set-2 scan codes, key bit positions and
// the scan-code to key lookup used by the decoder.
package ps2_key_decoder_pkg;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_LEFT    = 8'h6B;
  localparam logic [7:0] SC_UP      = 8'h75;
  localparam logic [7:0] SC_DOWN    = 8'h72;
  localparam logic [7:0] SC_RIGHT   = 8'h74;
  localparam logic [7:0] SC_RETRY   = 8'h2D;
  localparam logic [7:0] SC_RETRACT = 8'h1A;
  localparam logic [7:0] SC_NEXT    = 8'h31;
  localparam logic [7:0] SC_SWITCH  = 8'h29;

  localparam int KEY_LEFT    = 7;
  localparam int KEY_UP      = 6;
  localparam int KEY_DOWN    = 5;
  localparam int KEY_RIGHT   = 4;
  localparam int KEY_RETRY   = 3;
  localparam int KEY_RETRACT = 2;
  localparam int KEY_NEXT    = 1;
  localparam int KEY_SWITCH  = 0;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_hit_t;

  // Arrows exist only as extended codes; the letter keys only as plain codes.
  function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] code);
    key_hit_t r;
    r.hit = 1'b0;
    r.idx = 3'd0;
    if (ext) begin
      case (code)
        SC_LEFT:  begin r.hit = 1'b1; r.idx = 3'(KEY_LEFT);  end
        SC_UP:    begin r.hit = 1'b1; r.idx = 3'(KEY_UP);    end
        SC_DOWN:  begin r.hit = 1'b1; r.idx = 3'(KEY_DOWN);  end
        SC_RIGHT: begin r.hit = 1'b1; r.idx = 3'(KEY_RIGHT); end
        default:  r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_RETRY:   begin r.hit = 1'b1; r.idx = 3'(KEY_RETRY);   end
        SC_RETRACT: begin r.hit = 1'b1; r.idx = 3'(KEY_RETRACT); end
        SC_NEXT:    begin r.hit = 1'b1; r.idx = 3'(KEY_NEXT);    end
        SC_SWITCH:  begin r.hit = 1'b1; r.idx = 3'(KEY_SWITCH);  end
        default:    r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_frame_rx.sv
// PS/2 frame receiver: synchronizes and de-glitches the bus, then assembles
// 11-bit frames (start, 8 data LSB-first, odd parity, stop) into bytes.
module ps2_frame_rx
  import ps2_key_decoder_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          clk_s_p0, clk_s_p1, dat_s_p0, dat_s_p1;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall_p2, dat_p2;

  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_ok;
  logic [TW-1:0] tmo_cnt;

  // Stage p0/p1: synchronizers. Stage p2: filtered clock edge with aligned data.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s_p0 <= 1'b1;
      clk_s_p1 <= 1'b1;
      dat_s_p0 <= 1'b1;
      dat_s_p1 <= 1'b1;
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall_p2  <= 1'b0;
      dat_p2   <= 1'b1;
    end else begin
      clk_s_p0 <= ps2_clk;
      clk_s_p1 <= clk_s_p0;
      dat_s_p0 <= ps2_data;
      dat_s_p1 <= dat_s_p0;
      dat_p2   <= dat_s_p1;
      fall_p2  <= 1'b0;
      if (clk_s_p1 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s_p1;
        filt_cnt <= '0;
        fall_p2  <= ~clk_s_p1;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  // Stage p3: frame FSM; the timeout only runs while a frame is open.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RX_IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      par_ok     <= 1'b0;
      tmo_cnt    <= '0;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == RX_IDLE || fall_p2) tmo_cnt <= '0;
      else                             tmo_cnt <= tmo_cnt + TW'(1);

      if (state != RX_IDLE && !fall_p2 && tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
        state     <= RX_IDLE;
        frame_err <= 1'b1;
      end else if (fall_p2) begin
        case (state)
          RX_IDLE: begin
            if (!dat_p2) begin
              state   <= RX_DATA;
              bit_cnt <= 3'd0;
            end
          end
          RX_DATA: begin
            shift   <= {dat_p2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            par_ok <= ^{shift, dat_p2};
            state  <= RX_STOP;
          end
          RX_STOP: begin
            if (dat_p2 && par_ok) begin
              rx_byte    <= shift;
              byte_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
            state <= RX_IDLE;
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end for the game core: turns make/break scan codes into
// one-cycle key pulses, suppressing typematic repeats with a held-key mask.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       ext, brk;
  logic [7:0] held;
  key_hit_t   hit;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  assign hit = key_lookup(ext, rx_byte);

  // Stage p4: prefix tracking and key pulse, one cycle after the byte lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext  <= 1'b0;
      brk  <= 1'b0;
      held <= 8'h00;
      key  <= 8'h00;
    end else begin
      key <= 8'h00;
      if (byte_valid) begin
        if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == SC_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (hit.hit) begin
            if (brk) begin
              held[hit.idx] <= 1'b0;
            end else if (!held[hit.idx]) begin
              held[hit.idx] <= 1'b1;
              key           <= 8'(1) << hit.idx;
            end
          end
        end
      end
    end
  end

endmodule
